// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Accepts ALU operations from two requesters through a round-robin arbiter,
// sequences them onto a shared external ALU over one or more EXEC cycles, and
// holds the result until the consumer accepts it.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid_i[1:0]  per-requester request valid
//   req_ready_o[1:0]  per-requester accept (at most one bit high, IDLE only)
//   req_op_i[5:0]     opcode, requester i at [3i+2:3i]
//   req_a_i/req_b_i   operands, requester i at [8i+7:8i]
//   rsp_valid_o       result available (DONE)
//   rsp_ready_i       result consumer accept
//   rsp_id_o          requester owning the result
//   rsp_data_o        result byte
//   rsp_cout_o        carry/borrow of add/sub, 0 otherwise
//   busy_o            high whenever not IDLE
//   alu_a_o/alu_b_o   operands to the shared ALU
//   alu_en_o[7:0]     one-hot ALU select (add,sub,mul,shift,or,not,xor,nand)
//   alu_shift_o       shifter direction, 1 = left
//   alu_result_i      ALU result
//   alu_cout_i        ALU carry/borrow
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid_i,
   output logic [1:0]  req_ready_o,
   input  logic [5:0]  req_op_i,
   input  logic [15:0] req_a_i,
   input  logic [15:0] req_b_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic        rsp_id_o,
   output logic [7:0]  rsp_data_o,
   output logic        rsp_cout_o,
   output logic        busy_o,
   output logic [7:0]  alu_a_o,
   output logic [7:0]  alu_b_o,
   output logic [7:0]  alu_en_o,
   output logic        alu_shift_o,
   input  logic [7:0]  alu_result_i,
   input  logic        alu_cout_i
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   localparam logic [2:0] OpAdd   = 3'd0;
   localparam logic [2:0] OpSub   = 3'd1;
   localparam logic [2:0] OpMul   = 3'd2;
   localparam logic [2:0] OpShift = 3'd3;

   // MUL_LAT of 0 is treated as a single cycle; the counter is 3 bits wide.
   localparam int         MulCycles = (MUL_LAT < 1) ? 1 : ((MUL_LAT > 7) ? 7 : MUL_LAT);
   localparam logic [2:0] MulLast   = 3'(MulCycles - 1);

   state_t      state_q, state_d;
   logic [2:0]  op_q;
   logic [7:0]  a_q, b_q, work_q;
   logic        id_q, last_q;
   logic [2:0]  cnt_q;
   logic [7:0]  rsp_data_q;
   logic        rsp_cout_q;

   logic [1:0]  grant;
   logic        handshake;
   logic        selId;
   logic [2:0]  selOp;
   logic [7:0]  selA, selB;
   logic [2:0]  selCnt;
   logic        lastExec;
   logic        isShift;
   logic        zeroShift;

   // Round-robin: on contention the requester that did not win last time goes.
   always_comb begin
      grant = 2'b00;
      case (req_valid_i)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   assign selId     = grant[1];
   assign selOp     = selId ? req_op_i[5:3] : req_op_i[2:0];
   assign selA      = selId ? req_a_i[15:8] : req_a_i[7:0];
   assign selB      = selId ? req_b_i[15:8] : req_b_i[7:0];
   assign handshake = (state_q == IDLE) && (grant != 2'b00);

   // Counter is loaded with (EXEC length - 1); shift by zero still takes one cycle.
   always_comb begin
      selCnt = 3'd0;
      if (selOp == OpMul) begin
         selCnt = MulLast;
      end else if (selOp == OpShift) begin
         selCnt = (selB[2:0] == 3'd0) ? 3'd0 : (selB[2:0] - 3'd1);
      end
   end

   assign lastExec  = (cnt_q == 3'd0);
   assign isShift   = (op_q == OpShift);
   assign zeroShift = isShift && (b_q[2:0] == 3'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      req_ready_o = 2'b00;
      alu_en_o    = 8'h00;
      rsp_valid_o = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_o = grant;
            if (handshake) state_d = EXEC;
         end
         EXEC: begin
            alu_en_o = 8'h01 << op_q;
            if (lastExec) state_d = DONE;
         end
         DONE: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q       <= 3'd0;
         a_q        <= 8'h00;
         b_q        <= 8'h00;
         work_q     <= 8'h00;
         id_q       <= 1'b0;
         last_q     <= 1'b1;
         cnt_q      <= 3'd0;
         rsp_data_q <= 8'h00;
         rsp_cout_q <= 1'b0;
      end else begin
         if (handshake) begin
            op_q   <= selOp;
            a_q    <= selA;
            b_q    <= selB;
            work_q <= selA;
            id_q   <= selId;
            last_q <= selId;
            cnt_q  <= selCnt;
         end else if (state_q == EXEC) begin
            if (!lastExec) cnt_q <= cnt_q - 3'd1;
            // The shifter moves one bit per cycle, so feed its result back.
            if (isShift && !zeroShift) work_q <= alu_result_i;
            if (lastExec) begin
               rsp_data_q <= zeroShift ? a_q : alu_result_i;
               rsp_cout_q <= ((op_q == OpAdd) || (op_q == OpSub)) ? alu_cout_i : 1'b0;
            end
         end
      end
   end

   assign busy_o      = (state_q != IDLE);
   assign rsp_id_o    = id_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_cout_o  = rsp_cout_q;
   assign alu_a_o     = isShift ? work_q : a_q;
   assign alu_b_o     = b_q;
   assign alu_shift_o = isShift ? b_q[3] : 1'b0;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: provides a behavioural shared ALU, applies a
// table of directed operations, hand-written arbitration / stall / reset
// sequences and randomized operations checked against a reference model.
module tb_alu_op_sequencer;

   localparam int MUL_LAT = 2;

   logic        clk = 1'b0;
   logic        rstN;
   logic [1:0]  reqValid;
   logic [1:0]  reqReady;
   logic [5:0]  reqOp;
   logic [15:0] reqA, reqB;
   logic        rspValid, rspReady, rspId, rspCout, busy;
   logic [7:0]  rspData;
   logic [7:0]  aluA, aluB, aluEn, aluResult;
   logic        aluShift, aluCout;

   int checks = 0;
   int errors = 0;
   logic tbLast;

   alu_op_sequencer #(.MUL_LAT(MUL_LAT)) dut (
      .clk          (clk),
      .rst_n        (rstN),
      .req_valid_i  (reqValid),
      .req_ready_o  (reqReady),
      .req_op_i     (reqOp),
      .req_a_i      (reqA),
      .req_b_i      (reqB),
      .rsp_valid_o  (rspValid),
      .rsp_ready_i  (rspReady),
      .rsp_id_o     (rspId),
      .rsp_data_o   (rspData),
      .rsp_cout_o   (rspCout),
      .busy_o       (busy),
      .alu_a_o      (aluA),
      .alu_b_o      (aluB),
      .alu_en_o     (aluEn),
      .alu_shift_o  (aluShift),
      .alu_result_i (aluResult),
      .alu_cout_i   (aluCout)
   );

   always #5 clk = ~clk;

   // Shared ALU: the shifter moves one bit per enabled cycle.
   always_comb begin
      logic [8:0] wide;
      wide      = 9'h000;
      aluResult = 8'h00;
      aluCout   = 1'b0;
      case (aluEn)
         8'h01: begin wide = {1'b0, aluA} + {1'b0, aluB}; aluResult = wide[7:0]; aluCout = wide[8]; end
         8'h02: begin wide = {1'b0, aluA} - {1'b0, aluB}; aluResult = wide[7:0]; aluCout = wide[8]; end
         8'h04: aluResult = 8'(aluA * aluB);
         8'h08: aluResult = aluShift ? (aluA << 1) : (aluA >> 1);
         8'h10: aluResult = aluA | aluB;
         8'h20: aluResult = ~aluA;
         8'h40: aluResult = aluA ^ aluB;
         8'h80: aluResult = ~(aluA & aluB);
         default: aluResult = 8'h00;
      endcase
   end

   // Reference: whole-operation result, computed directly from the operands.
   task automatic refOp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] data, output logic cout, output int cyc);
      int s;
      cout = 1'b0;
      cyc  = 1;
      case (op)
         3'd0: begin s = int'(a) + int'(b); data = 8'(s); cout = (s > 255); end
         3'd1: begin data = 8'(int'(a) - int'(b)); cout = (a < b); end
         3'd2: begin data = 8'(int'(a) * int'(b)); cyc = (MUL_LAT < 1) ? 1 : MUL_LAT; end
         3'd3: begin
            data = b[3] ? (a << b[2:0]) : (a >> b[2:0]);
            cyc  = (b[2:0] == 3'd0) ? 1 : int'(b[2:0]);
         end
         3'd4: data = a | b;
         3'd5: data = ~a;
         3'd6: data = a ^ b;
         default: data = ~(a & b);
      endcase
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation: grant, EXEC cycle count and enables, DONE hold, return to IDLE.
   task automatic applyStimulus(input logic [1:0] valid, input logic [5:0] op,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic expId, input logic [7:0] expData,
                                input logic expCout, input int expCyc, input int stall);
      logic [2:0] opSel;
      logic [7:0] bSel;
      logic [7:0] expEn;
      logic       expShift;
      int         n;
      opSel    = expId ? op[5:3] : op[2:0];
      bSel     = expId ? b[15:8] : b[7:0];
      expEn    = 8'h01 << opSel;
      expShift = (opSel == 3'd3) ? bSel[3] : 1'b0;
      reqValid = valid; reqOp = op; reqA = a; reqB = b; rspReady = 1'b0;
      #1;
      checkOutput("grant", {30'd0, reqReady}, expId ? 32'd2 : 32'd1);
      checkOutput("idleEn", {24'd0, aluEn}, 32'd0);
      tick();
      n = 0;
      while (busy && !rspValid && n < 20) begin
         checkOutput("execEn", {24'd0, aluEn}, {24'd0, expEn});
         checkOutput("execShift", {31'd0, aluShift}, {31'd0, expShift});
         checkOutput("execReady", {30'd0, reqReady}, 32'd0);
         n++;
         tick();
      end
      checkOutput("execCycles", n, expCyc);
      for (int s = 0; s < stall; s++) begin
         checkOutput("holdValid", {31'd0, rspValid}, 32'd1);
         checkOutput("holdData", {24'd0, rspData}, {24'd0, expData});
         checkOutput("holdReady", {30'd0, reqReady}, 32'd0);
         checkOutput("doneEn", {24'd0, aluEn}, 32'd0);
         tick();
      end
      rspReady = 1'b1;
      #1;
      checkOutput("rspValid", {31'd0, rspValid}, 32'd1);
      checkOutput("rspData", {24'd0, rspData}, {24'd0, expData});
      checkOutput("rspCout", {31'd0, rspCout}, {31'd0, expCout});
      checkOutput("rspId", {31'd0, rspId}, {31'd0, expId});
      checkOutput("doneBusy", {31'd0, busy}, 32'd1);
      tick();
      reqValid = 2'b00; rspReady = 1'b0;
      #1;
      checkOutput("idleBusy", {31'd0, busy}, 32'd0);
      checkOutput("idleRspValid", {31'd0, rspValid}, 32'd0);
      tbLast = expId;
   endtask

   typedef struct {
      logic       id;
      logic [2:0] op;
      logic [7:0] a, b, expData;
      logic       expCout;
      int         expCyc;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [7:0] d;
      logic       c;
      int         cy;
      logic [1:0] v;
      logic       w;
      logic [5:0] o;
      logic [15:0] ra, rb;

      vecs[0]  = '{1'b0, 3'd0, 8'hF0, 8'h20, 8'h10, 1'b1, 1};
      vecs[1]  = '{1'b1, 3'd2, 8'h03, 8'h05, 8'h0F, 1'b0, 2};
      vecs[2]  = '{1'b0, 3'd3, 8'h01, 8'h0B, 8'h08, 1'b0, 3};
      vecs[3]  = '{1'b1, 3'd3, 8'h01, 8'h08, 8'h01, 1'b0, 1};
      vecs[4]  = '{1'b0, 3'd1, 8'h10, 8'h20, 8'hF0, 1'b1, 1};
      vecs[5]  = '{1'b1, 3'd1, 8'h20, 8'h10, 8'h10, 1'b0, 1};
      vecs[6]  = '{1'b0, 3'd4, 8'hA0, 8'h05, 8'hA5, 1'b0, 1};
      vecs[7]  = '{1'b1, 3'd5, 8'h3C, 8'h00, 8'hC3, 1'b0, 1};
      vecs[8]  = '{1'b0, 3'd6, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1};
      vecs[9]  = '{1'b1, 3'd7, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1};
      vecs[10] = '{1'b0, 3'd3, 8'h80, 8'h05, 8'h04, 1'b0, 5};
      vecs[11] = '{1'b1, 3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1};

      reqValid = 2'b00; reqOp = '0; reqA = '0; reqB = '0; rspReady = 1'b0;
      rstN = 1'b0;
      tbLast = 1'b1;
      #12;
      checkOutput("rstReady", {30'd0, reqReady}, 32'd0);
      checkOutput("rstBusy", {31'd0, busy}, 32'd0);
      checkOutput("rstRsp", {22'd0, rspValid, rspId, rspData}, 32'd0);
      checkOutput("rstAlu", {7'd0, aluA, aluB, aluEn, aluShift}, 32'd0);
      tick();
      rstN = 1'b1;
      tick();

      // Contention right after reset alternates starting with requester 0.
      for (int k = 0; k < 4; k++) begin
         o  = {3'd0, 3'd4};
         ra = 16'h1122 + 16'(k);
         rb = 16'h4400;
         w  = ~tbLast;
         refOp(w ? o[5:3] : o[2:0], w ? ra[15:8] : ra[7:0], w ? rb[15:8] : rb[7:0], d, c, cy);
         checkOutput("arbWinner", {31'd0, w}, k % 2);
         applyStimulus(2'b11, o, ra, rb, w, d, c, cy, 0);
      end

      // Directed table, operands placed in both requester slots.
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].id ? 2'b10 : 2'b01, {vecs[i].op, vecs[i].op},
                       {vecs[i].a, vecs[i].a}, {vecs[i].b, vecs[i].b},
                       vecs[i].id, vecs[i].expData, vecs[i].expCout, vecs[i].expCyc, 0);
      end

      // Consumer stalls for 5 cycles while both requesters keep asking.
      refOp(3'd6, 8'h5A, 8'hFF, d, c, cy);
      applyStimulus(2'b11, {3'd6, 3'd6}, 16'h5A5A, 16'hFFFF, ~tbLast, d, c, cy, 5);

      // Reset in the middle of a multiply discards it.
      reqValid = 2'b01; reqOp = {3'd0, 3'd2}; reqA = 16'h0003; reqB = 16'h0005;
      tick();
      reqValid = 2'b00;
      checkOutput("midExecEn", {24'd0, aluEn}, 32'h04);
      #2 rstN = 1'b0;
      #1;
      checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
      checkOutput("midRstRsp", {21'd0, rspValid, rspId, rspCout, rspData}, 32'd0);
      checkOutput("midRstAlu", {7'd0, aluA, aluB, aluEn, aluShift}, 32'd0);
      tick();
      rstN = 1'b1;
      tbLast = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checkOutput("postRstIdle", {30'd0, rspValid, busy}, 32'd0);
         tick();
      end
      refOp(3'd0, 8'h01, 8'h02, d, c, cy);
      applyStimulus(2'b11, {3'd1, 3'd0}, 16'h0901, 16'h0102, 1'b0, d, c, cy, 0);

      // Randomized operations against the reference model.
      for (int k = 0; k < 40; k++) begin
         v  = 2'($urandom_range(1, 3));
         o  = 6'($urandom);
         ra = 16'($urandom);
         rb = 16'($urandom);
         w  = (v == 2'b11) ? ~tbLast : v[1];
         refOp(w ? o[5:3] : o[2:0], w ? ra[15:8] : ra[7:0], w ? rb[15:8] : rb[7:0], d, c, cy);
         applyStimulus(v, o, ra, rb, w, d, c, cy, $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
